vend_sequencer: RTL and testbench

Transaction controller for the vending machine datapath. It accumulates inserted coins into a credit register and handles item selection against a fixed price table. It also sequences the vend handshake to the product dispenser and pays change one coin at a time through a coin-dispenser handshake. It sits between the coin acceptor / keypad front end and the product and change dispensers, and feeds the credit and price displays.

---
 rtl/vend_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_vend_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_sequencer.sv
// Vending transaction controller: coin credit, priced selection,
// vend handshake and greedy one-coin-per-cycle change payout.
module vend_sequencer #(
    parameter int PRICE_A1   = 75,
    parameter int PRICE_A2   = 100,
    parameter int PRICE_A3   = 125,
    parameter int PRICE_B1   = 50,
    parameter int PRICE_B2   = 150,
    parameter int PRICE_B3   = 200,
    parameter int PRICE_C1   = 25,
    parameter int PRICE_C2   = 250,
    parameter int PRICE_C3   = 65,
    parameter int MAX_CREDIT = 1000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [5:0]  coin,
    input  logic [8:0]  sel,
    input  logic        cancel,
    input  logic        vend_ack,
    input  logic        chg_ready,
    output logic [1:0]  state,
    output logic [10:0] credit,
    output logic [10:0] price_disp,
    output logic        vend_valid,
    output logic [8:0]  vend_item,
    output logic        chg_valid,
    output logic [5:0]  chg_coin,
    output logic        coin_reject,
    output logic        insufficient
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CREDIT = 2'd1,
        VEND   = 2'd2,
        CHANGE = 2'd3
    } state_t;

    localparam logic [11:0] MAX_C = 12'(MAX_CREDIT);

    state_t      state_q, state_d;
    logic [10:0] credit_q, credit_d;
    logic [10:0] price_q, price_d;
    logic [8:0]  item_q, item_d;
    logic [5:0]  chg_q, chg_d;
    logic        reject_q, reject_d;
    logic        insuff_q, insuff_d;

    logic        coin_ok, sel_ok, coin_fits, coin_take;
    logic [10:0] coin_val, sel_price, add_val, paid_val;

    function automatic logic [10:0] coin_value(input logic [5:0] c);
        logic [10:0] v;
        case (c)
            6'b000001: v = 11'd5;
            6'b000010: v = 11'd10;
            6'b000100: v = 11'd25;
            6'b001000: v = 11'd50;
            6'b010000: v = 11'd100;
            6'b100000: v = 11'd500;
            default:   v = 11'd0;
        endcase
        return v;
    endfunction

    function automatic logic [10:0] price_of(input logic [8:0] s);
        logic [10:0] p;
        case (s)
            9'h001:  p = 11'(PRICE_A1);
            9'h002:  p = 11'(PRICE_A2);
            9'h004:  p = 11'(PRICE_A3);
            9'h008:  p = 11'(PRICE_B1);
            9'h010:  p = 11'(PRICE_B2);
            9'h020:  p = 11'(PRICE_B3);
            9'h040:  p = 11'(PRICE_C1);
            9'h080:  p = 11'(PRICE_C2);
            9'h100:  p = 11'(PRICE_C3);
            default: p = 11'd0;
        endcase
        return p;
    endfunction

    // Largest coin not exceeding the remaining credit.
    function automatic logic [5:0] greedy(input logic [10:0] c);
        logic [5:0] g;
        if (c >= 11'd500)      g = 6'b100000;
        else if (c >= 11'd100) g = 6'b010000;
        else if (c >= 11'd50)  g = 6'b001000;
        else if (c >= 11'd25)  g = 6'b000100;
        else if (c >= 11'd10)  g = 6'b000010;
        else if (c >= 11'd5)   g = 6'b000001;
        else                   g = 6'b000000;
        return g;
    endfunction

    assign coin_ok   = (coin != '0) && ((coin & (coin - 6'd1)) == '0);
    assign sel_ok    = (sel != '0) && ((sel & (sel - 9'd1)) == '0);
    assign coin_val  = coin_value(coin);
    assign sel_price = price_of(sel);
    assign paid_val  = coin_value(chg_q);
    assign coin_fits = ({1'b0, credit_q} + {1'b0, coin_val}) <= MAX_C;
    assign coin_take = coin_ok && coin_fits &&
                       (state_q == IDLE || state_q == CREDIT);
    assign add_val   = coin_take ? coin_val : 11'd0;

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        price_d  = price_q;
        item_d   = item_q;
        reject_d = (coin != '0) && !coin_take;
        insuff_d = 1'b0;
        case (state_q)
            IDLE: begin
                credit_d = credit_q + add_val;
                if (sel_ok) price_d = sel_price;
                if (coin_take) state_d = CREDIT;
            end
            CREDIT: begin
                credit_d = credit_q + add_val;
                if (cancel) begin
                    state_d = CHANGE;
                end else if (sel_ok) begin
                    price_d = sel_price;
                    // Price is checked against the pre-coin credit.
                    if (credit_q >= sel_price) begin
                        credit_d = credit_q - sel_price + add_val;
                        item_d   = sel;
                        state_d  = VEND;
                    end else begin
                        insuff_d = 1'b1;
                    end
                end
            end
            VEND: begin
                if (vend_ack) begin
                    item_d  = '0;
                    state_d = (credit_q != '0) ? CHANGE : IDLE;
                end
            end
            CHANGE: begin
                if (chg_q != '0 && chg_ready) begin
                    credit_d = credit_q - paid_val;
                    if (credit_d == '0) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        chg_d = (state_d == CHANGE) ? greedy(credit_d) : 6'd0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            credit_q <= '0;
            price_q  <= '0;
            item_q   <= '0;
            chg_q    <= '0;
            reject_q <= 1'b0;
            insuff_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            price_q  <= price_d;
            item_q   <= item_d;
            chg_q    <= chg_d;
            reject_q <= reject_d;
            insuff_q <= insuff_d;
        end
    end

    assign state        = state_q;
    assign credit       = credit_q;
    assign price_disp   = price_q;
    assign vend_valid   = (state_q == VEND);
    assign vend_item    = item_q;
    assign chg_valid    = (chg_q != '0);
    assign chg_coin     = chg_q;
    assign coin_reject  = reject_q;
    assign insufficient = insuff_q;

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed bench for vend_sequencer: browse/buy, refunds, backpressure,
// overflow rejects, simultaneous events and asynchronous reset.
module tb_vend_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic [5:0]  coin;
    logic [8:0]  sel;
    logic        cancel;
    logic        vend_ack;
    logic        chg_ready;
    logic [1:0]  state;
    logic [10:0] credit;
    logic [10:0] price_disp;
    logic        vend_valid;
    logic [8:0]  vend_item;
    logic        chg_valid;
    logic [5:0]  chg_coin;
    logic        coin_reject;
    logic        insufficient;

    int checks = 0;
    int errors = 0;

    vend_sequencer dut (
        .clock(clock), .reset(reset), .coin(coin), .sel(sel),
        .cancel(cancel), .vend_ack(vend_ack), .chg_ready(chg_ready),
        .state(state), .credit(credit), .price_disp(price_disp),
        .vend_valid(vend_valid), .vend_item(vend_item),
        .chg_valid(chg_valid), .chg_coin(chg_coin),
        .coin_reject(coin_reject), .insufficient(insufficient)
    );

    always #5 clock = ~clock;

    // Apply the pending pulse inputs on one edge, then clear them.
    task automatic tick();
        @(posedge clock);
        #1;
        coin = '0; sel = '0; cancel = 1'b0; vend_ack = 1'b0;
    endtask

    task automatic drain();
        vend_ack = 1'b1;
        chg_ready = 1'b1;
        for (int i = 0; i < 20 && state !== 2'd0; i++) begin
            @(posedge clock);
            #1;
        end
        vend_ack = 1'b0;
        checks++;
        if (state !== 2'd0) begin
            errors++;
            $display("FAIL drain_timeout state=%0d want 0", state);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        coin = '0; sel = '0; cancel = 0; vend_ack = 0; chg_ready = 0;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if ({state, credit, price_disp, vend_valid, vend_item, chg_valid,
             chg_coin, coin_reject, insufficient} !== '0) begin
            errors++;
            $display("FAIL reset_outputs state=%0d credit=%0d price=%0d want all 0",
                     state, credit, price_disp);
        end
        reset = 1'b0;
    endtask

    task automatic test_browse_buy();
        sel = 9'h001; tick();
        checks++;
        if (price_disp !== 11'd75 || state !== 2'd0) begin
            errors++;
            $display("FAIL browse price=%0d state=%0d want 75/0", price_disp, state);
        end
        coin = 6'h10; tick();
        checks++;
        if (credit !== 11'd100 || state !== 2'd1) begin
            errors++;
            $display("FAIL dollar credit=%0d state=%0d want 100/1", credit, state);
        end
        sel = 9'h001; tick();
        checks++;
        if (vend_valid !== 1'b1 || vend_item !== 9'h001 || credit !== 11'd25) begin
            errors++;
            $display("FAIL buy_a1 valid=%0b item=%h credit=%0d want 1/001/25",
                     vend_valid, vend_item, credit);
        end
        tick();
        checks++;
        if (vend_valid !== 1'b1 || vend_item !== 9'h001 || state !== 2'd2) begin
            errors++;
            $display("FAIL vend_hold valid=%0b item=%h state=%0d want 1/001/2",
                     vend_valid, vend_item, state);
        end
        vend_ack = 1'b1; tick();
        checks++;
        if (state !== 2'd3 || chg_valid !== 1'b1 || chg_coin !== 6'h04 ||
            vend_item !== 9'h000) begin
            errors++;
            $display("FAIL vend_ack state=%0d chg_coin=%h item=%h want 3/04/000",
                     state, chg_coin, vend_item);
        end
        chg_ready = 1'b1; tick();
        checks++;
        if (state !== 2'd0 || credit !== 11'd0 || chg_valid !== 1'b0) begin
            errors++;
            $display("FAIL buy_change state=%0d credit=%0d chg_valid=%0b want 0/0/0",
                     state, credit, chg_valid);
        end
        chg_ready = 1'b0;
    endtask

    task automatic test_insufficient();
        coin = 6'h04; tick();
        coin = 6'h02; tick();
        sel = 9'h008; tick();
        checks++;
        if (insufficient !== 1'b1 || state !== 2'd1 || credit !== 11'd35 ||
            price_disp !== 11'd50) begin
            errors++;
            $display("FAIL insufficient ins=%0b state=%0d credit=%0d price=%0d want 1/1/35/50",
                     insufficient, state, credit, price_disp);
        end
        tick();
        checks++;
        if (insufficient !== 1'b0) begin
            errors++;
            $display("FAIL insufficient_pulse ins=%0b want 0", insufficient);
        end
        cancel = 1'b1;
        drain();
    endtask

    task automatic test_cancel_refund();
        logic [5:0] exp_coin [4];
        logic [10:0] exp_cred [4];
        exp_coin = '{6'h20, 6'h04, 6'h02, 6'h01};
        exp_cred = '{11'd540, 11'd40, 11'd15, 11'd5};
        coin = 6'h20; tick();
        coin = 6'h04; tick();
        coin = 6'h02; tick();
        coin = 6'h01; tick();
        checks++;
        if (credit !== 11'd540) begin
            errors++;
            $display("FAIL refund_credit credit=%0d want 540", credit);
        end
        chg_ready = 1'b1;
        cancel = 1'b1; tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (state !== 2'd3 || chg_coin !== exp_coin[i] || credit !== exp_cred[i]) begin
                errors++;
                $display("FAIL refund_step%0d coin=%h credit=%0d want %h/%0d",
                         i, chg_coin, credit, exp_coin[i], exp_cred[i]);
            end
            tick();
        end
        checks++;
        if (state !== 2'd0 || credit !== 11'd0 || chg_valid !== 1'b0) begin
            errors++;
            $display("FAIL refund_end state=%0d credit=%0d want 0/0", state, credit);
        end
        chg_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        coin = 6'h08; tick();
        coin = 6'h02; tick();
        cancel = 1'b1; tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (chg_coin !== 6'h08 || chg_valid !== 1'b1 || credit !== 11'd60) begin
                errors++;
                $display("FAIL bp_hold%0d coin=%h credit=%0d want 08/60",
                         i, chg_coin, credit);
            end
            tick();
        end
        chg_ready = 1'b1; tick();
        checks++;
        if (chg_coin !== 6'h02 || credit !== 11'd10) begin
            errors++;
            $display("FAIL bp_fifty coin=%h credit=%0d want 02/10", chg_coin, credit);
        end
        tick();
        checks++;
        if (state !== 2'd0 || credit !== 11'd0) begin
            errors++;
            $display("FAIL bp_end state=%0d credit=%0d want 0/0", state, credit);
        end
        chg_ready = 1'b0;
    endtask

    task automatic test_overflow();
        coin = 6'h20; tick();
        for (int i = 0; i < 5; i++) begin
            coin = 6'h10; tick();
        end
        checks++;
        if (credit !== 11'd1000 || coin_reject !== 1'b0) begin
            errors++;
            $display("FAIL fill_1000 credit=%0d rej=%0b want 1000/0", credit, coin_reject);
        end
        coin = 6'h01; tick();
        checks++;
        if (credit !== 11'd1000 || coin_reject !== 1'b1) begin
            errors++;
            $display("FAIL overflow credit=%0d rej=%0b want 1000/1", credit, coin_reject);
        end
        coin = 6'h03; tick();
        checks++;
        if (credit !== 11'd1000 || coin_reject !== 1'b1) begin
            errors++;
            $display("FAIL multihot credit=%0d rej=%0b want 1000/1", credit, coin_reject);
        end
        sel = 9'h180; tick();
        checks++;
        if (state !== 2'd1 || price_disp !== 11'd50 || coin_reject !== 1'b0) begin
            errors++;
            $display("FAIL multisel state=%0d price=%0d rej=%0b want 1/50/0",
                     state, price_disp, coin_reject);
        end
        sel = 9'h080; tick();
        checks++;
        if (state !== 2'd2 || credit !== 11'd750 || vend_item !== 9'h080) begin
            errors++;
            $display("FAIL buy_c2 state=%0d credit=%0d item=%h want 2/750/080",
                     state, credit, vend_item);
        end
        coin = 6'h04; tick();
        checks++;
        if (coin_reject !== 1'b1 || credit !== 11'd750 || state !== 2'd2) begin
            errors++;
            $display("FAIL vend_coin rej=%0b credit=%0d state=%0d want 1/750/2",
                     coin_reject, credit, state);
        end
        drain();
    endtask

    task automatic test_simultaneous();
        coin = 6'h10; tick();
        sel = 9'h001; coin = 6'h04; tick();
        checks++;
        if (state !== 2'd2 || credit !== 11'd50 || coin_reject !== 1'b0) begin
            errors++;
            $display("FAIL coin_sel state=%0d credit=%0d rej=%0b want 2/50/0",
                     state, credit, coin_reject);
        end
        drain();
        coin = 6'h10; tick();
        sel = 9'h002; cancel = 1'b1; coin = 6'h02; tick();
        checks++;
        if (state !== 2'd3 || price_disp !== 11'd75 || credit !== 11'd110 ||
            chg_coin !== 6'h10 || vend_valid !== 1'b0) begin
            errors++;
            $display("FAIL sel_cancel state=%0d price=%0d credit=%0d coin=%h want 3/75/110/10",
                     state, price_disp, credit, chg_coin);
        end
        drain();
        chg_ready = 1'b0;
    endtask

    task automatic test_reset_mid_change();
        coin = 6'h10; tick();
        cancel = 1'b1; tick();
        checks++;
        if (chg_valid !== 1'b1 || state !== 2'd3) begin
            errors++;
            $display("FAIL pre_reset chg_valid=%0b state=%0d want 1/3", chg_valid, state);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({state, credit, price_disp, vend_valid, vend_item, chg_valid,
             chg_coin, coin_reject, insufficient} !== '0) begin
            errors++;
            $display("FAIL async_reset state=%0d credit=%0d chg_valid=%0b want all 0",
                     state, credit, chg_valid);
        end
        @(negedge clock);
        reset = 1'b0;
        tick();
        checks++;
        if (state !== 2'd0 || credit !== 11'd0) begin
            errors++;
            $display("FAIL post_reset state=%0d credit=%0d want 0/0", state, credit);
        end
    endtask

    initial begin
        test_reset();
        test_browse_buy();
        test_insufficient();
        test_cancel_refund();
        test_backpressure();
        test_overflow();
        test_simultaneous();
        test_reset_mid_change();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
